// File: rtl/inv_key_exp.sv
// Reverse AES-128 key-schedule walker: streams round keys 10..0 over valid/ready.
// Optional abort input is enabled by defining INV_KEY_ABORT_EN.
module inv_key_exp #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  input  logic             rk_ready,
  output logic             rk_valid,
  output logic [KEY_W-1:0] rk_out,
  output logic [3:0]       rk_idx,
  output logic             busy,
  output logic             done
`ifdef INV_KEY_ABORT_EN
  ,
  input  logic             abort
`endif
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [3:0]       idx_q, idx_d;
  logic             done_q, done_d;
  logic [KEY_W-1:0] prev_key;
  logic             abort_req;

`ifdef INV_KEY_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Undo one expansion step: the three linear words are pairwise XORs, the
  // leading word needs G of the reconstructed last word with this round's RC.
  always_comb begin
    logic [31:0] k0, k1, k2, k3, p0, p1, p2, p3, g_w;
    k0 = key_q[127:96];
    k1 = key_q[95:64];
    k2 = key_q[63:32];
    k3 = key_q[31:0];
    p3 = k3 ^ k2;
    p2 = k2 ^ k1;
    p1 = k1 ^ k0;
    g_w = sub_word({p3[23:0], p3[31:24]}) ^ {rcon(idx_q), 24'h000000};
    p0 = k0 ^ g_w;
    prev_key = {p0, p1, p2, p3};
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          idx_d   = 4'(NR);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (abort_req) begin
          state_d = IDLE;
        end else if (rk_ready) begin
          if (idx_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = prev_key;
            idx_d = idx_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid = (state_q == EMIT);
  assign busy     = (state_q == EMIT);
  assign rk_out   = key_q;
  assign rk_idx   = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_inv_key_exp.sv
// Randomised self-checking bench for inv_key_exp against a word-level key-schedule model.
// Define INV_KEY_ABORT_EN to also exercise the abort input.
module tb_inv_key_exp;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         rk_ready = 1'b0;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         busy;
  logic         done;
`ifdef INV_KEY_ABORT_EN
  logic         abort = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_tbl [256];
  logic [127:0] exp_rk [11];
  logic [127:0] got [11];
  logic [127:0] got1 [11];
  int           last_latency;

  localparam logic [127:0] KEY_A1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  inv_key_exp dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .busy     (busy),
    .done     (done)
`ifdef INV_KEY_ABORT_EN
    ,
    .abort    (abort)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // GF(2^8) arithmetic used to derive the S-box and round constants.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [7:0] rc_of(input int round);
    logic [7:0] rc = 8'h01;
    for (int j = 1; j < round; j++) rc = gmul(rc, 8'h02);
    return rc;
  endfunction

  // Invert the schedule recurrence w[i] = w[i-4] ^ t(w[i-1]) from w40..w43 down to w0.
  task automatic build_ref(input logic [127:0] key10);
    logic [31:0] w [44];
    logic [31:0] t;
    {w[40], w[41], w[42], w[43]} = key10;
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
        t = t ^ {rc_of(i / 4), 24'h0};
      end
      w[i-4] = w[i] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // mode: 0 ready always, 1 ready pattern 1,0,0,..., 2 random ready.
  // poke_at / rst_at / abort_at: beat index for the injected event, -1 for none.
  // Returns in the done cycle (or right after an abort/reset has been checked).
  task automatic walk(input logic [127:0] key, input int mode, input int poke_at,
                      input int rst_at, input int abort_at);
    int   r = 10;
    int   cyc = 0;
    int   pat = 0;
    bit   rdy;
    bit   aborted;
    logic [127:0] seen;
    build_ref(key);
    start  = 1'b1;
    key_in = key;
    tick();
    cyc++;
    start  = 1'b0;
    key_in = '0;
    forever begin
      check("valid", 128'(rk_valid), 128'(1));
      check("busy", 128'(busy), 128'(1));
      check("done_low", 128'(done), 128'(0));
      check($sformatf("idx%0d", r), 128'(rk_idx), 128'(r));
      check($sformatf("rk%0d", r), rk_out, exp_rk[r]);
      seen = rk_out;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (pat % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      pat++;
      if (r == rst_at) begin
        RST = 1'b1;
        rk_ready = 1'b1;
        tick();
        RST = 1'b0;
        rk_ready = 1'b0;
        check("rst_valid", 128'(rk_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_idx", 128'(rk_idx), 128'(0));
        check("rst_rk", rk_out, 128'(0));
        tick();
        check("rst_no_done", 128'(done), 128'(0));
        return;
      end
      if (r == poke_at) begin
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      aborted = 1'b0;
`ifdef INV_KEY_ABORT_EN
      if (r == abort_at) begin
        abort   = 1'b1;
        rdy     = 1'b1;
        aborted = 1'b1;
      end
`endif
      rk_ready = rdy;
      tick();
      cyc++;
      start    = 1'b0;
      key_in   = '0;
      rk_ready = 1'b0;
`ifdef INV_KEY_ABORT_EN
      abort    = 1'b0;
`endif
      if (aborted) begin
        check("abort_valid", 128'(rk_valid), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        check("abort_idx", 128'(rk_idx), 128'(r));
        tick();
        check("abort_no_done", 128'(done), 128'(0));
        return;
      end
      if (rdy) begin
        got[r] = seen;
        if (r == 0) break;
        r--;
      end
      if (cyc > 300) begin
        check("timeout", 128'(cyc), 128'(0));
        return;
      end
    end
    check("end_done", 128'(done), 128'(1));
    check("end_busy", 128'(busy), 128'(0));
    check("end_valid", 128'(rk_valid), 128'(0));
    last_latency = cyc;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sbox_tbl[i] = sbox_calc(8'(i));

    tick();
    tick();
    check("reset_valid", 128'(rk_valid), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_idx", 128'(rk_idx), 128'(0));
    check("reset_rk", rk_out, 128'(0));
    RST = 1'b0;
    tick();

    // Known-answer walk with the consumer always ready.
    walk(KEY_A1, 0, -1, -1, -1);
    check("a1_rk10", got[10], KEY_A1);
    check("a1_rk9", got[9], 128'hac7766f319fadc2128d12941575c006e);
    check("a1_rk0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("a1_latency", 128'(last_latency), 128'(12));
    for (int i = 0; i <= 10; i++) got1[i] = got[i];
    tick();
    check("a1_done_once", 128'(done), 128'(0));

    // Backpressure: accepted beats must match the unthrottled walk.
    walk(KEY_A1, 1, -1, -1, -1);
    for (int i = 0; i <= 10; i++) check($sformatf("bp_beat%0d", i), got[i], got1[i]);
    tick();

    // Start pulsed mid-walk is ignored.
    walk(KEY_A1, 0, 5, -1, -1);
    check("poke_rk0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    tick();

    // Reset mid-walk, then a fresh walk.
    walk(KEY_A1, 2, -1, 7, -1);
    walk(KEY_A1, 2, -1, -1, -1);
    tick();

    // Random keys, random backpressure, with a back-to-back all-zero walk.
    for (int n = 0; n < 3; n++) walk({$urandom, $urandom, $urandom, $urandom}, 2, -1, -1, -1);
    walk(128'h0, 0, -1, -1, -1);
    check("b2b_rk10", got[10], 128'h0);
    tick();
    check("b2b_done_once", 128'(done), 128'(0));

`ifdef INV_KEY_ABORT_EN
    walk(KEY_A1, 0, -1, -1, 4);
    walk({$urandom, $urandom, $urandom, $urandom}, 2, -1, -1, -1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_key_exp.md
Name: inv_key_exp

Overview:
Reverse AES-128 key-schedule walker for the decryption datapath. It loads the final (round-10) round key and streams round keys 10, 9, … 0 one per accepted beat over a valid/ready handshake. Each step reconstructs the previous round key on the fly, so no 11-entry key store is needed. It is the inverse counterpart of the forward key expansion and reuses the existing G_func (with its S_BOX instances) for the one non-linear word per step.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported.
KEY_W, 128, round-key width in bits.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a walk; sampled only in IDLE.
key_in  input  KEY_W  round-10 key {w40,w41,w42,w43}, w40 in [127:96]; sampled with start.
rk_ready  input  1  consumer accepts the current beat.
rk_valid  output  1  rk_out/rk_idx hold a valid round key.
rk_out  output  KEY_W  current round key, same word order as key_in.
rk_idx  output  4  round index of rk_out (10 down to 0).
busy  output  1  high from the cycle after start until the cycle after the last beat is accepted.
done  output  1  one-cycle pulse the cycle after the round-0 beat is accepted.

Behaviour:
- Reset (RST=1 at a clock edge): state=IDLE; key_reg=0; idx=0; rk_valid=0; rk_out=0; rk_idx=0; busy=0; done=0. Reset applied mid-walk aborts immediately; no done pulse.
- States: IDLE and EMIT.
- IDLE: start=1 loads key_reg<=key_in and idx<=NR, then moves to EMIT. start in any other state is ignored.
- EMIT: rk_valid=1, rk_out=key_reg, rk_idx=idx, busy=1. All outputs are direct register outputs.
- Beat accepted (rk_valid & rk_ready):
  - If idx==0: go to IDLE, rk_valid<=0, done<=1 for exactly one cycle.
  - Else: key_reg<=prev(key_reg,idx) and idx<=idx-1.
- Beat not accepted (rk_ready=0): key_reg and idx hold; outputs stay stable (no change while valid and not ready).
- prev(k,r), with k={k0,k1,k2,k3}:
  - p3=k3^k2; p2=k2^k1; p1=k1^k0.
  - p0=k0^G(p3, rnd_num=r), where G is RotWord, then SubWord, then XOR of the top byte with RC[r] (RC[1..10]=01,02,04,08,10,20,40,80,1B,36).
  - Result is {p0,p1,p2,p3}. prev is combinational from key_reg; the S-box/XOR path lies in one cycle.
- Timing: start at edge n gives first beat (idx 10) valid after edge n. With rk_ready held at 1, there is one beat per cycle, 11 beats total. done is high in the cycle after the idx-0 beat, and busy is low in that same cycle.
- A new start is accepted in the same cycle done is high (state is IDLE).

Optional Feature:
Macro INV_KEY_ABORT_EN.
- Defined: adds input port abort (1 bit). When abort=1 in EMIT, the next state is IDLE with rk_valid=0 and busy=0, and done is not pulsed. abort has priority over a simultaneous accept. It is ignored in IDLE.
- Not defined: no abort port; a walk can only end via the round-0 beat or RST.

Test Plan:
1. FIPS-197 A.1 walk, rk_ready=1: key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 with start -> beat idx10 equals key_in; beat idx9=ac7766f319fadc2128d12941575c006e; beat idx0=2b7e151628aed2a6abf7158809cf4f3c; done pulses once, 12 cycles after start.
2. Backpressure: same key, rk_ready toggled 1,0,0,1,… -> rk_out/rk_idx stable while rk_ready=0; the sequence of accepted beats is identical to scenario 1.
3. Ignored start: pulse start with a different key_in at beat idx 5 -> walk unaffected, idx0 still 2b7e1516….
4. Reset mid-walk: RST at beat idx 7 -> next cycle all outputs 0, no done; a fresh start then produces the full correct sequence.
5. Back-to-back: start asserted in the done cycle with all-zero key_in -> new idx10 beat 00…00 on the next cycle, followed by 10 further beats ending at idx 0.
6. (INV_KEY_ABORT_EN) abort together with rk_ready at idx 4 -> rk_valid=0 next cycle, busy=0, no done, idx not decremented.
